// File: rtl/snd_pkg.sv
// Sound-effect definitions shared by the sequencer.
// Holds the effect ids, the note record, the note tables and lookup helpers.
package snd_pkg;

   typedef enum logic [1:0] {
      SFX_START = 2'd0,
      SFX_EAT   = 2'd1,
      SFX_OVER  = 2'd2
   } sfx_id_t;

   typedef struct packed {
      logic [15:0] freq;  // Hz, 0 = rest
      logic [11:0] dur;   // duration in ticks
   } note_t;

   localparam int unsigned MAX_NOTES = 4;
   localparam int unsigned NUM_SFX   = 3;

   localparam int unsigned SFX_LEN [NUM_SFX] = '{3, 1, 4};

   localparam note_t SFX_TABLE [NUM_SFX][MAX_NOTES] = '{
      '{'{16'd523, 12'd100}, '{16'd659, 12'd100}, '{16'd784, 12'd200}, '{16'd0, 12'd0}},
      '{'{16'd1047, 12'd50}, '{16'd0, 12'd0}, '{16'd0, 12'd0}, '{16'd0, 12'd0}},
      '{'{16'd392, 12'd150}, '{16'd0, 12'd50}, '{16'd330, 12'd150}, '{16'd262, 12'd300}}
   };

   // Table lookup; a zero duration would never tick out, so it plays as one tick.
   function automatic note_t note_at(sfx_id_t id, logic [1:0] idx);
      note_t n;
      n = SFX_TABLE[id][idx];
      if (n.dur == 12'd0) begin
         n.dur = 12'd1;
      end
      return n;
   endfunction

   function automatic logic is_last_note(sfx_id_t id, logic [1:0] idx);
      return ({30'd0, idx} + 32'd1) >= SFX_LEN[id];
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Restartable clock divider producing the note-duration tick.
// Ports:
//   clk     - system clock
//   reset_n - synchronous active-low reset
//   restart - forces the count back to 0 (takes priority over counting)
//   tick    - high during the last clock of each DIV-clock period
module tick_prescaler #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned     CntW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset_n || restart) begin
         cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays note tables into the speaker tone generator.
// Ports:
//   clk     - system clock
//   reset_n - synchronous active-low reset
//   req     - one-cycle request pulses (bit0 START, bit1 EAT, bit2 OVER)
//   mute    - level, silences freq without disturbing timing
//   freq    - tone frequency in Hz, 0 = silent
//   busy    - high while an effect plays
//   sfx_id  - effect playing or last played
//   done    - one-cycle pulse on natural completion of an effect
module sfx_sequencer
   import snd_pkg::*;
#(
   parameter int unsigned FCLK    = 50_000_000,
   parameter int unsigned TICK_HZ = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  req,
   input  logic        mute,
   output logic [31:0] freq,
   output logic        busy,
   output logic [1:0]  sfx_id,
   output logic        done
);

   localparam int unsigned DIV = FCLK / TICK_HZ;

   if (DIV < 2) begin : g_div_check
      $error("sfx_sequencer: FCLK/TICK_HZ must be at least 2");
   end

   typedef enum logic [0:0] {StIdle, StPlay} state_t;

   state_t      state_q, state_d;
   sfx_id_t     sfx_id_q, sfx_id_d;
   logic [1:0]  note_idx_q, note_idx_d;
   logic [15:0] note_freq_q, note_freq_d;
   logic [11:0] remain_q, remain_d;
   logic        done_q, done_d;

   logic        restart;
   logic        tick;
   sfx_id_t     winner;
   logic        accept;
   note_t       nt;

   tick_prescaler #(
      .DIV(DIV)
   ) u_tick_prescaler (
      .clk    (clk),
      .reset_n(reset_n),
      .restart(restart),
      .tick   (tick)
   );

   // Highest-index request wins; the losers are simply dropped.
   always_comb begin
      winner = SFX_START;
      if (req[2]) begin
         winner = SFX_OVER;
      end else if (req[1]) begin
         winner = SFX_EAT;
      end
   end

   // While playing, only a strictly higher-priority effect may preempt.
   assign accept = (req != 3'b000) && ((state_q == StIdle) || (winner > sfx_id_q));

   always_comb begin
      state_d     = state_q;
      sfx_id_d    = sfx_id_q;
      note_idx_d  = note_idx_q;
      note_freq_d = note_freq_q;
      remain_d    = remain_q;
      done_d      = 1'b0;
      restart     = 1'b0;
      nt          = note_at(sfx_id_q, note_idx_q + 2'd1);

      if (accept) begin
         // Preemption outranks a completion on the same edge, so no done pulse.
         nt          = note_at(winner, 2'd0);
         state_d     = StPlay;
         sfx_id_d    = winner;
         note_idx_d  = 2'd0;
         note_freq_d = nt.freq;
         remain_d    = nt.dur;
         restart     = 1'b1;
      end else if (state_q == StPlay && tick) begin
         if (remain_q == 12'd1) begin
            if (is_last_note(sfx_id_q, note_idx_q)) begin
               state_d     = StIdle;
               note_freq_d = 16'd0;
               done_d      = 1'b1;
            end else begin
               // Next note loads on the same edge so notes abut with no gap.
               note_idx_d  = note_idx_q + 2'd1;
               note_freq_d = nt.freq;
               remain_d    = nt.dur;
            end
         end else begin
            remain_d = remain_q - 12'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         sfx_id_q    <= SFX_START;
         note_idx_q  <= 2'd0;
         note_freq_q <= 16'd0;
         remain_q    <= 12'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sfx_id_q    <= sfx_id_d;
         note_idx_q  <= note_idx_d;
         note_freq_q <= note_freq_d;
         remain_q    <= remain_d;
         done_q      <= done_d;
      end
   end

   assign freq   = mute ? 32'd0 : {16'd0, note_freq_q};
   assign busy   = (state_q == StPlay);
   assign sfx_id = sfx_id_q;
   assign done   = done_q;

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
Sound-effect controller that sequences note tables into the speaker tone generator. It takes one-cycle event requests from game logic (game start, food eaten, game over) and arbitrates between them by fixed priority. It drives the 32-bit frequency word and note timing; the downstream tone generator's reset_n is tied to the same system reset. It emits 0 Hz (silence) when idle, muted, or on rest notes.

Parameters:
FCLK, 50_000_000, system clock frequency in Hz
TICK_HZ, 1000, duration tick rate; 1000 gives note durations in ms; DIV = FCLK/TICK_HZ clocks per tick, DIV >= 2 (elaboration assert)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, synchronous, active-low
req  input  3  one-cycle request pulses; bit0 START, bit1 EAT, bit2 OVER
mute  input  1  level; forces freq to 0, sequencing continues
freq  output  32  tone frequency in Hz to tone generator, 0 = silent
busy  output  1  high while an effect is playing
sfx_id  output  2  id of the effect playing or last played (0 START, 1 EAT, 2 OVER)
done  output  1  one-cycle pulse when an effect completes naturally

Behaviour:
- Reset: freq=0, busy=0, sfx_id=0, done=0, state IDLE, note index 0, tick counters 0; reset mid-playback aborts with no done pulse.
- Priority: OVER(2) > EAT(1) > START(0); on simultaneous req bits the highest index wins; lower ones are dropped, not queued.
- Acceptance: in IDLE any req bit is accepted; in PLAY only a req of strictly higher priority than sfx_id is accepted (preemption); equal or lower are ignored.
- Accept at edge N: sfx_id<=winner, note_idx<=0, freq<=table freq of note 0 (0 if mute), remain<=dur, prescaler<=0, busy<=1, state PLAY. freq changes at edge N (visible cycle after req sampled).
- States: IDLE -> PLAY on accept; PLAY -> PLAY on next note or preemption; PLAY -> IDLE after last note.
- Note timing: restartable prescaler counts 0..DIV-1; tick on DIV-1; remain decrements per tick; note lasts exactly dur*DIV cycles. dur=0 in table is treated as 1.
- Note advance: when remain reaches 0 on a tick, if note_idx+1 < SFX_LEN[sfx_id] load next note in the same edge (no gap cycle); else freq<=0, busy<=0, done<=1 for one cycle, state IDLE.
- Preemption on the exact finishing edge: preemption wins, no done pulse.
- Rest notes: table freq 0 plays silence for dur ticks.
- mute: freq output = mute ? 0 : note freq, combinational from registered note freq and mute; timing unaffected.
- Widths: table freq 16-bit unsigned, zero-extended to 32; dur 12-bit; remain 12-bit; prescaler width clog2(DIV).

Decomposition:
- Package snd_pkg: sfx_id_t enum (SFX_START=0, SFX_EAT=1, SFX_OVER=2); note_t struct {freq[15:0], dur[11:0]}; MAX_NOTES=4; SFX_LEN={3,1,4}; SFX_TABLE[3][4]:
  START: 523/100, 659/100, 784/200
  EAT: 1047/50
  OVER: 392/150, 0/50, 330/150, 262/300
- Sub-module tick_prescaler (parameter DIV; inputs clk, reset_n, restart; output tick).

Test Plan:
- Bench parameters: FCLK=1000, TICK_HZ=100 (DIV=10).
- Reset: hold reset_n=0 mid-START -> next edge freq=0, busy=0, done=0; no done pulse afterwards.
- EAT pulse from IDLE -> freq=1047 from the following cycle for exactly 500 cycles, then freq=0, busy=0, done high for 1 cycle, sfx_id=1.
- START pulse -> freq 523 for 1000 cycles, 659 for 1000, 784 for 2000, no gap cycles; done after 4000 cycles.
- OVER pulse 300 cycles into EAT -> freq=392 next cycle, sfx_id=2, no done for EAT; sequence 392, 0, 330, 262 with 1500/500/1500/3000 cycle lengths.
- EAT or START pulse during OVER -> ignored, OVER completes unchanged.
- req=3'b011 simultaneously -> EAT wins (sfx_id=1, freq=1047).
- mute=1 during START -> freq=0 throughout; busy high; done still pulses at 4000 cycles.
